// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: repeats a PAT_W-bit pattern MSB-first into a
// sequence detector, with optional idle gaps and a mark on each final bit.
module seq_gen_serial #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic             d_o,
  output logic             valid_o,
  output logic             mark_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] TOP = BW'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    logic [GAP_W-1:0] gap;
  } cfg_t;

  state_t           state_q, state_n;
  cfg_t             cfg_q, cfg_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [GAP_W-1:0] gcnt_q, gcnt_n;
  logic [BW-1:0]    bit_q, bit_n;
  logic             done_n, d_n, valid_n, mark_n, busy_n;

  // Outputs are registered copies of what the next state implies, so the
  // stream lines up with the state that produced it and no input leaks out.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      rep_q   <= '0;
      gcnt_q  <= '0;
      bit_q   <= '0;
      d_o     <= 1'b0;
      valid_o <= 1'b0;
      mark_o  <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_n;
      cfg_q   <= cfg_n;
      rep_q   <= rep_n;
      gcnt_q  <= gcnt_n;
      bit_q   <= bit_n;
      d_o     <= d_n;
      valid_o <= valid_n;
      mark_o  <= mark_n;
      busy_o  <= busy_n;
      done_o  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cfg_n   = cfg_q;
    rep_n   = rep_q;
    gcnt_n  = gcnt_q;
    bit_n   = bit_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is meaningless here, so a simultaneous start simply wins
        if (start_i) begin
          cfg_n.pat = pattern_i;
          cfg_n.gap = gap_i;
          rep_n     = count_i;
          bit_n     = TOP;
          gcnt_n    = '0;
          if (count_i != '0) state_n = SEND;
          else               done_n  = 1'b1;
        end
      end
      SEND: begin
        if (abort_i) begin
          state_n = IDLE;
          rep_n   = '0;
          bit_n   = '0;
          gcnt_n  = '0;
        end else if (bit_q == '0) begin
          rep_n = rep_q - CNT_W'(1);
          bit_n = TOP;
          if (rep_q == CNT_W'(1)) begin
            state_n = IDLE;
            bit_n   = '0;
            done_n  = 1'b1;
          end else if (cfg_q.gap != '0) begin
            state_n = GAP;
            gcnt_n  = cfg_q.gap;
          end
        end else begin
          bit_n = bit_q - BW'(1);
        end
      end
      GAP: begin
        if (abort_i) begin
          state_n = IDLE;
          rep_n   = '0;
          bit_n   = '0;
          gcnt_n  = '0;
        end else if (gcnt_q <= GAP_W'(1)) begin
          state_n = SEND;
          bit_n   = TOP;
          gcnt_n  = '0;
        end else begin
          gcnt_n = gcnt_q - GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    valid_n = (state_n == SEND);
    d_n     = valid_n & cfg_n.pat[bit_n];
    mark_n  = valid_n && (bit_n == '0);
    busy_n  = (state_n != IDLE);
  end

endmodule

// File: tb/tb_seq_gen_serial.sv
// Directed bench for seq_gen_serial: cycle tables plus hand-written abort,
// ignored-start and async-reset sequences, with a 10110 Mealy detector model.
module tb_seq_gen_serial;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, abort_i;
  logic [4:0] pattern_i;
  logic [7:0] count_i;
  logic [3:0] gap_i;
  logic       d_o, valid_o, mark_o, busy_o, done_o;

  seq_gen_serial dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .pattern_i(pattern_i), .count_i(count_i), .gap_i(gap_i),
    .d_o(d_o), .valid_o(valid_o), .mark_o(mark_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // overlapping Mealy detector for 10110 fed by d_o
  logic [3:0] hist;
  logic       sd;
  always @(posedge clk_i or negedge rst_i)
    if (!rst_i) hist <= 4'b0;
    else        hist <= {hist[2:0], d_o};
  assign sd = ({hist, d_o} == 5'b10110);

  typedef struct {
    logic       st;
    logic       ab;
    logic [4:0] pat;
    logic [7:0] cnt;
    logic [3:0] gap;
    logic [4:0] exp;   // {d, valid, mark, busy, done}
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] expq[$];
  int         sd_all, sd_mark;

  function automatic logic [4:0] outs();
    return {d_o, valid_o, mark_o, busy_o, done_o};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (d,valid,mark,busy,done) t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic [4:0] pat, input logic [7:0] cnt,
                     input logic [3:0] gap, input logic [4:0] exp);
    vec_t v;
    v.st = st; v.ab = 1'b0; v.pat = pat; v.cnt = cnt; v.gap = gap; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // expected cycles following an accepted start, built from the pattern list
  task automatic build(input logic [4:0] pat, input int cnt, input int gap);
    expq.delete();
    for (int r = 0; r < cnt; r++) begin
      for (int b = 4; b >= 0; b--)
        expq.push_back({pat[b], 1'b1, (b == 0), 1'b1, 1'b0});
      if (r < cnt - 1)
        for (int g = 0; g < gap; g++) expq.push_back(5'b00010);
    end
    expq.push_back(5'b00001);
    expq.push_back(5'b00000);
  endtask

  task automatic run_model(input string name, input logic [4:0] pat, input int cnt,
                           input int gap);
    build(pat, cnt, gap);
    sd_all = 0; sd_mark = 0;
    start_i = 1'b1; pattern_i = pat; count_i = 8'(cnt); gap_i = 4'(gap);
    foreach (expq[i]) begin
      step();
      start_i = 1'b0; pattern_i = 5'h0; count_i = 8'h0; gap_i = 4'h0;
      check(name, outs(), expq[i]);
      if (sd) sd_all++;
      if (sd && mark_o) sd_mark++;
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
    pattern_i = 5'h0; count_i = 8'h0; gap_i = 4'h0;
    #1;
    check("reset_now", outs(), 5'b00000);
    step(); step();
    check("reset_hold", outs(), 5'b00000);
    #3 rst_i = 1'b1;
    step();
    check("idle_after_rst", outs(), 5'b00000);

    // count=1, gap=0
    add(1, 5'b10110, 8'd1, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b01010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b01110);
    add(0, 5'b0, 8'd0, 4'd0, 5'b00001);
    add(0, 5'b0, 8'd0, 4'd0, 5'b00000);
    // count=2, gap=2
    add(1, 5'b10110, 8'd2, 4'd2, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b01010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b01110);
    add(0, 5'b0, 8'd0, 4'd0, 5'b00010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b00010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b01010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b11010);
    add(0, 5'b0, 8'd0, 4'd0, 5'b01110);
    add(0, 5'b0, 8'd0, 4'd0, 5'b00001);
    add(0, 5'b0, 8'd0, 4'd0, 5'b00000);

    foreach (vecs[i]) begin
      start_i = vecs[i].st; abort_i = vecs[i].ab;
      pattern_i = vecs[i].pat; count_i = vecs[i].cnt; gap_i = vecs[i].gap;
      step();
      check($sformatf("table[%0d]", i), outs(), vecs[i].exp);
    end
    start_i = 1'b0;

    // back-to-back repetitions through the detector model
    run_model("cnt3_gap0", 5'b10110, 3, 0);
    check_int("sd_pulses", sd_all, 3);
    check_int("sd_on_mark", sd_mark, 3);

    run_model("cnt0", 5'b10110, 0, 3);
    run_model("cnt2_gap1_alt", 5'b11001, 2, 1);

    // start while busy must be ignored
    build(5'b10110, 2, 0);
    start_i = 1'b1; pattern_i = 5'b10110; count_i = 8'd2; gap_i = 4'd0;
    for (int c = 1; c <= 12; c++) begin
      step();
      start_i = (c == 3); pattern_i = 5'b11111; count_i = 8'd5; gap_i = 4'd1;
      check($sformatf("ignore_start c%0d", c), outs(), expq[c-1]);
    end
    start_i = 1'b0;

    // abort at edge k+3
    build(5'b10110, 2, 0);
    start_i = 1'b1; pattern_i = 5'b10110; count_i = 8'd2; gap_i = 4'd0;
    for (int c = 1; c <= 14; c++) begin
      step();
      start_i = 1'b0;
      abort_i = (c == 3);
      check($sformatf("abort c%0d", c), outs(), (c <= 3) ? expq[c-1] : 5'b00000);
    end
    abort_i = 1'b0;

    // abort while idle is harmless; start with abort still launches
    abort_i = 1'b1; start_i = 1'b1; pattern_i = 5'b10110; count_i = 8'd1; gap_i = 4'd0;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    check("start_beats_abort", outs(), 5'b11010);
    for (int c = 0; c < 6; c++) step();
    check("settled", outs(), 5'b00000);

    // async reset mid-send
    start_i = 1'b1; pattern_i = 5'b10110; count_i = 8'd3; gap_i = 4'd0;
    step();
    start_i = 1'b0;
    step(); step();
    check("pre_async_rst", outs(), 5'b11010);
    #3 rst_i = 1'b0;
    #1 check("async_rst", outs(), 5'b00000);
    step();
    check("async_rst_hold", outs(), 5'b00000);
    #3 rst_i = 1'b1;
    step();
    check("post_rst_idle", outs(), 5'b00000);
    run_model("post_rst", 5'b10110, 1, 0);
    check_int("post_rst_sd", sd_mark, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_gen_serial.md
Name: seq_gen_serial

Overview:
- Serial pattern transmitter that drives a single-bit stream, registered and MSB-first, into the sequence-detector input d_i.
- Sends a programmable PAT_W-bit pattern a programmable number of times, with a programmable run of idle zeros between repetitions.
- mark_o flags the cycle in which the detector's Mealy output sd_o must fire, so the pair can be self-checked.
- Sits between bench/control logic and the detector.

Parameters:
PAT_W, 5, pattern width in bits (default targets 10110 detection)
CNT_W, 8, width of repetition count
GAP_W, 4, width of inter-pattern idle-bit count

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  launch request; sampled only while busy_o=0
abort_i  input  1  synchronous abort of a transfer in progress
pattern_i  input  PAT_W  pattern to send; latched on accepted start
count_i  input  CNT_W  repetitions; latched on accepted start
gap_i  input  GAP_W  idle bits between repetitions; latched on accepted start
d_o  output  1  serial data bit (connect to detector d_i)
valid_o  output  1  d_o carries a pattern bit
mark_o  output  1  high while d_o carries bit 0 (last bit) of a repetition
busy_o  output  1  transfer in progress
done_o  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (rst_i=0, asynchronous): all outputs 0 immediately; state IDLE; all counters 0. Outputs stay 0 until the first accepted start after rst_i returns high.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, SEND, GAP.
- Accepted start: start_i=1 while busy_o=0, including the cycle where done_o=1.
  - start_i while busy_o=1 is ignored.
  - pattern_i, count_i and gap_i are don't-care except at the accept edge.
- IDLE, start accepted at edge k, count_i!=0:
  - Latch inputs; rep_cnt=count_i; bit_idx=PAT_W-1; go to SEND.
  - Cycle k+1: d_o=pattern[PAT_W-1], valid_o=1, busy_o=1.
- IDLE, start accepted at edge k, count_i=0:
  - No bits sent; stay IDLE.
  - done_o=1 in cycle k+1 only; busy_o and valid_o stay 0.
- SEND:
  - One bit per cycle: d_o=pattern[bit_idx], bit_idx decrements.
  - mark_o=1 exactly when bit_idx=0.
  - After bit 0, rep_cnt decrements. Then, in priority order:
    - Last repetition: go to IDLE; next cycle d_o=0, valid_o=0, busy_o=0, done_o=1.
    - gap=0: next cycle sends pattern[PAT_W-1] of the next repetition (back-to-back; exercises overlap).
    - Otherwise: go to GAP for gap cycles.
- GAP:
  - d_o=0, valid_o=0, mark_o=0, busy_o=1.
  - After gap cycles, SEND restarts at bit PAT_W-1.
- abort_i=1 at any edge while busy_o=1: next cycle returns to IDLE with all outputs 0. done_o is not pulsed. abort_i while idle has no effect.
- Simultaneous start_i and abort_i while idle: start wins.
- Repetition length is count_i in the range 1..2^CNT_W-1; no wrap. Bit counter width is clog2(PAT_W).

Test Plan:
- pattern=10110, count=1, gap=0, start at edge k -> d_o 1,0,1,1,0 in cycles k+1..k+5; valid_o=1 k+1..k+5; mark_o only at k+5; done_o only at k+6; busy_o low at k+6.
- pattern=10110, count=3, gap=0 -> stream 101101011010110 in k+1..k+15; mark_o at k+5, k+10, k+15; done_o at k+16. Driving the detector gives exactly 3 sd_o pulses, each coincident with mark_o.
- pattern=10110, count=2, gap=2 -> 10110, 0(valid 0), 0(valid 0), 10110; mark_o at k+5 and k+12; done_o at k+13.
- count=0, start at edge k -> done_o=1 at k+1 only; valid_o, busy_o and mark_o never assert.
- count=2, gap=0; start_i pulsed again at k+3 -> ignored, stream unchanged. Separate run: abort_i at edge k+3 -> cycle k+4 has valid_o=0, busy_o=0, and done_o never asserts.
- Assert rst_i=0 asynchronously mid-SEND (between clock edges) -> all outputs 0 before the next edge. After release, a fresh start with count=1 sends 10110 cleanly.
